// File: rtl/axi_ad7124_pkg.sv
// Shared types and constants for the AD7124 multi-board scan controller.
package axi_ad7124_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        COMMIT = 2'd3
    } scan_state_t;

    localparam logic [31:0] MIN_PERIOD           = 32'd2;
    localparam int          NUM_OF_BOARD_DEFAULT = 6;

    // Scan period actually used: short programmed periods are stretched to the minimum.
    function automatic logic [31:0] eff_period(input logic [31:0] period);
        return (period < MIN_PERIOD) ? MIN_PERIOD : period;
    endfunction

endpackage

// File: rtl/axi_ad7124_tick_gen.sv
// Free-running scan period counter; raises tick on the last count of each period.
module axi_ad7124_tick_gen
    import axi_ad7124_pkg::*;
(
    input  logic        aclk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] period,
    output logic        tick
);

    logic [31:0] count_r;
    logic [31:0] last_s;

    assign last_s = eff_period(period) - 32'd1;
    // >= rather than == so a period shortened mid-count wraps instead of running away.
    assign tick   = enable && (count_r >= last_s);

    // Period counter, parked at zero while scanning is disabled.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 32'd0;
        end else if (!enable) begin
            count_r <= 32'd0;
        end else if (count_r >= last_s) begin
            count_r <= 32'd0;
        end else begin
            count_r <= count_r + 32'd1;
        end
    end

endmodule

// File: rtl/axi_ad7124_scan_ctrl.sv
// Sequences periodic readouts across NUM_OF_BOARD AD7124 boards and hands
// completed frames to a ping-pong BRAM writer with overrun/timeout tracking.
module axi_ad7124_scan_ctrl
    import axi_ad7124_pkg::*;
#(
    parameter int NUM_OF_BOARD = NUM_OF_BOARD_DEFAULT,
    parameter int SEQ_WIDTH    = 32
)
(
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cfg_enable,
    input  logic [31:0]             cfg_period,
    input  logic [23:0]             cfg_timeout,
    output logic [NUM_OF_BOARD-1:0] start,
    input  logic [NUM_OF_BOARD-1:0] done,
    output logic                    commit,
    output logic                    commit_bank,
    output logic [SEQ_WIDTH-1:0]    commit_seq,
    output logic [NUM_OF_BOARD-1:0] commit_mask,
    input  logic                    host_ack,
    input  logic                    host_ack_bank,
    input  logic                    err_clr,
    output logic                    timeout_err,
    output logic                    overrun_err,
    output logic                    busy
);

    localparam logic [SEQ_WIDTH-1:0] SEQ_ONE = {{(SEQ_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]              rst_sync_r;
    logic                    rst_int_n_s;
    logic                    tick_s;

    scan_state_t             state_r;
    logic [NUM_OF_BOARD-1:0] start_r;
    logic [NUM_OF_BOARD-1:0] done_seen_r;
    logic [23:0]             tmo_cnt_r;
    logic                    commit_r;
    logic                    commit_bank_r;
    logic [SEQ_WIDTH-1:0]    commit_seq_r;
    logic [NUM_OF_BOARD-1:0] commit_mask_r;
    logic [SEQ_WIDTH-1:0]    seq_r;
    logic                    bank_r;
    logic [1:0]              pending_r;
    logic                    timeout_err_r;
    logic                    overrun_err_r;
    logic                    busy_r;

    logic [NUM_OF_BOARD-1:0] done_seen_nx_s;
    logic                    all_done_s;
    logic                    tmo_expire_s;
    logic [1:0]              ack_clr_s;
    logic [1:0]              commit_set_s;
    logic [1:0]              pending_nx_s;
    logic                    ovr_set_s;
    logic                    tmo_set_s;

    // Reset release synchroniser: assertion is immediate, deassertion takes two edges.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_sync_r[1];

    axi_ad7124_tick_gen u_tick_gen (
        .aclk   (aclk),
        .rst_n  (rst_int_n_s),
        .enable (cfg_enable),
        .period (cfg_period),
        .tick   (tick_s)
    );

    // Completion/timeout detection and per-bank pending bookkeeping.
    always_comb begin
        done_seen_nx_s = done_seen_r | done;
        all_done_s     = &done_seen_nx_s;
        tmo_expire_s   = (tmo_cnt_r == 24'd1);
        ack_clr_s      = 2'b00;
        commit_set_s   = 2'b00;
        if (host_ack) begin
            ack_clr_s[host_ack_bank] = 1'b1;
        end else begin
            ack_clr_s = 2'b00;
        end
        if (state_r == COMMIT) begin
            commit_set_s[commit_bank_r] = 1'b1;
        end else begin
            commit_set_s = 2'b00;
        end
        // An ack landing with the commit frees the old frame first, so no overrun.
        pending_nx_s = (pending_r & ~ack_clr_s) | commit_set_s;
        ovr_set_s    = (tick_s && (state_r != IDLE)) ||
                       (|(commit_set_s & pending_r & ~ack_clr_s));
        tmo_set_s    = (state_r == COMMIT) && !(&commit_mask_r);
    end

    // Scan sequencer with registered strobes, frame tags and sticky errors.
    always_ff @(posedge aclk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_r       <= IDLE;
            start_r       <= '0;
            done_seen_r   <= '0;
            tmo_cnt_r     <= 24'd0;
            commit_r      <= 1'b0;
            commit_bank_r <= 1'b0;
            commit_seq_r  <= '0;
            commit_mask_r <= '0;
            seq_r         <= '0;
            bank_r        <= 1'b0;
            pending_r     <= 2'b00;
            timeout_err_r <= 1'b0;
            overrun_err_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            start_r       <= '0;
            commit_r      <= 1'b0;
            pending_r     <= pending_nx_s;
            overrun_err_r <= ovr_set_s | (overrun_err_r & ~err_clr);
            timeout_err_r <= tmo_set_s | (timeout_err_r & ~err_clr);
            case (state_r)
                IDLE: begin
                    if (tick_s && cfg_enable) begin
                        state_r <= START;
                        start_r <= '1;
                        busy_r  <= 1'b1;
                    end
                end
                START: begin
                    done_seen_r <= done;
                    tmo_cnt_r   <= cfg_timeout;
                    state_r     <= WAIT;
                end
                WAIT: begin
                    done_seen_r <= done_seen_nx_s;
                    if (tmo_cnt_r != 24'd0) begin
                        tmo_cnt_r <= tmo_cnt_r - 24'd1;
                    end
                    if (all_done_s || tmo_expire_s) begin
                        state_r       <= COMMIT;
                        commit_r      <= 1'b1;
                        commit_mask_r <= done_seen_nx_s;
                        commit_bank_r <= bank_r;
                        commit_seq_r  <= seq_r;
                    end
                end
                COMMIT: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    seq_r   <= seq_r + SEQ_ONE;
                    bank_r  <= ~bank_r;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign start       = start_r;
    assign commit      = commit_r;
    assign commit_bank = commit_bank_r;
    assign commit_seq  = commit_seq_r;
    assign commit_mask = commit_mask_r;
    assign timeout_err = timeout_err_r;
    assign overrun_err = overrun_err_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_axi_ad7124_scan_ctrl.sv
// Self-checking bench: directed scenarios plus randomized scans against a frame-level model.
module tb_axi_ad7124_scan_ctrl;

    localparam int          NB  = 6;
    localparam int          SW  = 32;
    localparam logic [63:0] ALL = 64'h3F;

    logic          aclk;
    logic          aresetn;
    logic          cfg_enable;
    logic [31:0]   cfg_period;
    logic [23:0]   cfg_timeout;
    logic [NB-1:0] start;
    logic [NB-1:0] done;
    logic          commit;
    logic          commit_bank;
    logic [SW-1:0] commit_seq;
    logic [NB-1:0] commit_mask;
    logic          host_ack;
    logic          host_ack_bank;
    logic          err_clr;
    logic          timeout_err;
    logic          overrun_err;
    logic          busy;

    axi_ad7124_scan_ctrl #(.NUM_OF_BOARD(NB), .SEQ_WIDTH(SW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_enable    (cfg_enable),
        .cfg_period    (cfg_period),
        .cfg_timeout   (cfg_timeout),
        .start         (start),
        .done          (done),
        .commit        (commit),
        .commit_bank   (commit_bank),
        .commit_seq    (commit_seq),
        .commit_mask   (commit_mask),
        .host_ack      (host_ack),
        .host_ack_bank (host_ack_bank),
        .err_clr       (err_clr),
        .timeout_err   (timeout_err),
        .overrun_err   (overrun_err),
        .busy          (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level model of what the host should see.
    logic [SW-1:0] m_seq;
    logic          m_bank;
    logic [1:0]    m_pend;
    int            last_start;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic reconfig(input int period);
        cfg_enable = 1'b0;
        repeat (2) @(negedge aclk);
        cfg_period = 32'(period);
        cfg_enable = 1'b1;
    endtask

    // d[i] = cycle offset from the start cycle at which board i reports done, -1 = never.
    task automatic run_scan(input int d [NB], input int tmo, input int ack_mode, input bit clr_at_commit,
                            input int exp_gap, input bit exp_drop, input int dis_k);
        int            k_commit;
        int            exp_c;
        int            compl;
        logic [NB-1:0] exp_mask;
        bit            exp_terr;
        bit            exp_ovr;
        bit            found;
        cfg_timeout = 24'(tmo);
        found = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge aclk);
            if (start !== '0) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("start_seen", 64'(found), 64'd1);
        if (!found) return;
        if (exp_gap > 0) check_eq("start_gap", 64'(cyc - last_start), 64'(exp_gap));
        last_start = cyc;
        check_eq("start_all", 64'(start), ALL);
        check_eq("busy_scan", 64'(busy), 64'd1);

        compl = 0;
        for (int i = 0; i < NB; i++) begin
            if (d[i] < 0) compl = 100000;
            else if (d[i] > compl) compl = d[i];
        end
        if (compl < 1) compl = 1;
        if (tmo != 0 && tmo < compl) begin
            exp_c    = tmo + 1;
            exp_terr = 1'b1;
            for (int i = 0; i < NB; i++) exp_mask[i] = (d[i] >= 0) && (d[i] <= tmo);
        end else begin
            exp_c    = compl + 1;
            exp_terr = 1'b0;
            exp_mask = '1;
        end

        k_commit = -1;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) @(negedge aclk);
            if (k == 1) check_eq("start_pulse_len", 64'(start), 64'd0);
            if (commit === 1'b1) begin
                k_commit = k;
                break;
            end
            if (k == dis_k) cfg_enable = 1'b0;
            for (int i = 0; i < NB; i++) done[i] = (d[i] == k);
        end
        done = '0;
        check_eq("commit_latency", 64'(k_commit), 64'(exp_c));
        if (k_commit < 0) return;
        check_eq("commit_mask", 64'(commit_mask), 64'(exp_mask));
        check_eq("commit_bank", 64'(commit_bank), 64'(m_bank));
        check_eq("commit_seq", 64'(commit_seq), 64'(m_seq));

        exp_ovr = exp_drop || (m_pend[m_bank] && ack_mode != 1);
        m_pend[m_bank] = 1'b1;
        if (ack_mode == 1) begin
            host_ack      = 1'b1;
            host_ack_bank = m_bank;
        end
        err_clr = clr_at_commit;
        @(negedge aclk);
        host_ack = 1'b0;
        err_clr  = 1'b0;
        check_eq("commit_pulse_len", 64'(commit), 64'd0);
        check_eq("busy_idle", 64'(busy), 64'd0);
        check_eq("seq_held", 64'(commit_seq), 64'(m_seq));
        check_eq("overrun_err", 64'(overrun_err), 64'(exp_ovr));
        check_eq("timeout_err", 64'(timeout_err), 64'(exp_terr));
        if (ack_mode == 2) begin
            host_ack       = 1'b1;
            host_ack_bank  = m_bank;
            m_pend[m_bank] = 1'b0;
        end
        err_clr = 1'b1;
        @(negedge aclk);
        host_ack = 1'b0;
        err_clr  = 1'b0;
        @(negedge aclk);
        check_eq("err_cleared", 64'({timeout_err, overrun_err}), 64'd0);
        m_seq  = m_seq + 1;
        m_bank = ~m_bank;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dl [NB];
        int rp;
        int tmo;
        bit any_start;
        aresetn       = 1'b0;
        cfg_enable    = 1'b0;
        cfg_period    = 32'd100;
        cfg_timeout   = 24'd0;
        done          = '0;
        host_ack      = 1'b0;
        host_ack_bank = 1'b0;
        err_clr       = 1'b0;
        m_seq         = '0;
        m_bank        = 1'b0;
        m_pend        = 2'b00;
        last_start    = 0;
        repeat (3) @(negedge aclk);
        check_eq("reset_outputs", {start, commit, commit_bank, commit_seq, commit_mask,
                                   timeout_err, overrun_err, busy}, 64'd0);
        aresetn = 1'b1;
        repeat (4) @(negedge aclk);
        check_eq("idle_after_reset", 64'({busy, start}), 64'd0);

        // Nominal periodic scanning, all boards answer 10 cycles after start ends.
        reconfig(100);
        dl = '{11, 11, 11, 11, 11, 11};
        run_scan(dl, 0, 2, 1'b0, 0, 1'b0, -1);
        run_scan(dl, 0, 2, 1'b0, 100, 1'b0, -1);
        run_scan(dl, 0, 2, 1'b0, 100, 1'b0, -1);

        // Host stops acknowledging; then an ack lands in the commit cycle.
        run_scan(dl, 0, 0, 1'b0, 100, 1'b0, -1);
        run_scan(dl, 0, 0, 1'b0, 100, 1'b0, -1);
        run_scan(dl, 0, 0, 1'b0, 100, 1'b0, -1);
        run_scan(dl, 0, 1, 1'b0, 100, 1'b0, -1);
        host_ack = 1'b1;
        host_ack_bank = 1'b0;
        @(negedge aclk);
        host_ack_bank = 1'b1;
        @(negedge aclk);
        host_ack = 1'b0;
        m_pend = 2'b00;

        // Board 3 silent: timeout commits a partial frame; second time err_clr collides with the set.
        dl = '{11, 11, 11, -1, 11, 11};
        run_scan(dl, 50, 2, 1'b0, 100, 1'b0, -1);
        run_scan(dl, 50, 2, 1'b1, 100, 1'b0, -1);

        // Enable drops mid-scan: frame still commits, then no further scans.
        dl = '{8, 8, 8, 8, 8, 8};
        run_scan(dl, 0, 2, 1'b0, 100, 1'b0, 3);
        any_start = 1'b0;
        for (int n = 0; n < 150; n++) begin
            @(negedge aclk);
            if (start !== '0) any_start = 1'b1;
        end
        check_eq("no_start_disabled", 64'(any_start), 64'd0);

        // Scan longer than the period: one tick dropped, cadence kept.
        reconfig(20);
        dl = '{30, 30, 30, 30, 30, 30};
        run_scan(dl, 0, 2, 1'b0, 0, 1'b1, -1);
        dl = '{5, 5, 5, 5, 5, 5};
        run_scan(dl, 0, 2, 1'b0, 40, 1'b0, -1);

        // Reset asserted while waiting for boards.
        for (int n = 0; n < 100; n++) begin
            @(negedge aclk);
            if (start !== '0) break;
        end
        repeat (3) @(negedge aclk);
        check_eq("busy_before_reset", 64'(busy), 64'd1);
        #2 aresetn = 1'b0;
        #1 check_eq("async_reset_outputs", {start, commit, commit_bank, commit_seq, commit_mask,
                                            timeout_err, overrun_err, busy}, 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        m_seq  = '0;
        m_bank = 1'b0;
        m_pend = 2'b00;
        run_scan(dl, 0, 2, 1'b0, 0, 1'b0, -1);

        // Sequence number wrap.
        force dut.seq_r = 32'hFFFF_FFFF;
        @(negedge aclk);
        release dut.seq_r;
        m_seq = 32'hFFFF_FFFF;
        run_scan(dl, 0, 2, 1'b0, 0, 1'b0, -1);
        run_scan(dl, 0, 2, 1'b0, 20, 1'b0, -1);

        // Randomized scans: random answer times, timeouts, ack behaviour and err_clr timing.
        rp = int'($urandom_range(60, 150));
        reconfig(rp);
        for (int s = 0; s < 24; s++) begin
            tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(15, 50));
            for (int i = 0; i < NB; i++) begin
                if (tmo != 0 && $urandom_range(0, 5) == 0) dl[i] = -1;
                else dl[i] = int'($urandom_range(0, 40));
            end
            run_scan(dl, tmo, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                     (s == 0) ? 0 : rp, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_ad7124_scan_ctrl.md
AXI_AD7124_SCAN_CTRL -- requirements
Module: axi_ad7124_scan_ctrl

Interface
REQ-001 Parameter NUM_OF_BOARD, default 6, number of AD7124 boards sequenced per scan.
REQ-002 Parameter SEQ_WIDTH, default 32, width of the frame sequence counter.
REQ-003 aclk  in  1  single clock for all logic.
REQ-004 aresetn  in  1  reset; asynchronous, active-low.
REQ-005 cfg_enable  in  1  level; 1 = periodic scanning enabled.
REQ-006 cfg_period  in  32  scan period in aclk cycles; values below 2 are treated as 2.
REQ-007 cfg_timeout  in  24  WAIT timeout in aclk cycles; 0 = timeout disabled.
REQ-008 start  out  NUM_OF_BOARD  one-cycle pulse per board; launches a readout on that board's SPI engine.
REQ-009 done  in  NUM_OF_BOARD  one-cycle pulse per board; that board's readout is complete.
REQ-010 commit  out  1  one-cycle pulse; the frame is ready for the BRAM writer.
REQ-011 commit_bank  out  1  ping-pong bank for this frame; valid when commit=1, held otherwise.
REQ-012 commit_seq  out  SEQ_WIDTH  frame sequence number; valid when commit=1, held otherwise.
REQ-013 commit_mask  out  NUM_OF_BOARD  boards whose done was seen in this scan; valid when commit=1.
REQ-014 host_ack  in  1  one-cycle pulse; host has consumed bank host_ack_bank.
REQ-015 host_ack_bank  in  1  bank being acknowledged.
REQ-016 err_clr  in  1  one-cycle pulse; clears the sticky errors.
REQ-017 timeout_err  out  1  sticky; a scan committed with an incomplete mask.
REQ-018 overrun_err  out  1  sticky; a tick was dropped or an unacknowledged bank was overwritten.
REQ-019 busy  out  1  1 while the FSM is in any state other than IDLE.

Function
REQ-020 Period counter runs while cfg_enable=1, counts 0..P-1 with P = max(cfg_period, 2), and raises an internal tick on the count P-1; it is held at 0 while cfg_enable=0.
REQ-021 FSM has four states: IDLE, START, WAIT and COMMIT.
REQ-022 IDLE->START on tick with cfg_enable=1; start is all-ones for exactly the one START cycle, which is the cycle after the tick.
REQ-023 START clears the done_seen register, loads the timeout counter, and always moves to WAIT.
REQ-024 done_seen ORs in done during START and WAIT; a done in the START cycle counts.
REQ-025 WAIT->COMMIT the cycle after done_seen (including the current done) becomes all-ones.
REQ-026 WAIT->COMMIT when cfg_timeout≠0 and cfg_timeout cycles have elapsed in WAIT; timeout_err is set and commit_mask is the partial done_seen.
REQ-027 COMMIT lasts 1 cycle, asserts commit, then returns to IDLE.
REQ-028 After each commit, commit_seq increments, wrapping from all-ones to 0; the first commit after reset carries seq 0.
REQ-029 commit_bank alternates 0,1,0,… starting at 0.
REQ-030 Per-bank pending bit: set at commit, cleared by host_ack for host_ack_bank.
REQ-031 A commit to a bank whose pending bit is set still proceeds and sets overrun_err.
REQ-032 host_ack and commit to the same bank in the same cycle: pending ends at 1 and overrun_err is not set.
REQ-033 A tick while busy=1 is dropped and sets overrun_err; the period counter is not disturbed.
REQ-034 cfg_enable falling mid-scan: the scan completes through COMMIT, then the FSM stays in IDLE.
REQ-035 A done outside START/WAIT is ignored.
REQ-036 err_clr in the same cycle as an error set: the set wins.

Reset
REQ-037 On aresetn=0 all outputs go to 0, the FSM goes to IDLE, and the counters, done_seen and pending bits clear; these are asynchronous.
REQ-038 Release of reset is synchronised internally with a 2-flop deassertion synchroniser.

Structure
REQ-039 Package axi_ad7124_pkg holds the state enum scan_state_t and the constants MIN_PERIOD=2 and the default NUM_OF_BOARD=6.
REQ-040 The period counter/tick generator is one sub-module, axi_ad7124_tick_gen; everything else is flat.

Verification
REQ-041 cfg_period=100, all boards done 10 cycles after start -> start every 100 cycles, commit 12 cycles after start, mask 0x3F, seq 0,1,2, bank 0,1,0.
REQ-042 cfg_timeout=50, board 3 never done -> commit at WAIT cycle 50, mask 0x37, timeout_err=1; err_clr clears it.
REQ-043 cfg_period=20, done after 30 cycles -> tick dropped, overrun_err=1, no second start until IDLE.
REQ-044 No host_ack for 3 commits -> overrun_err set at the 3rd commit (bank 0 reused); ack bank in the same cycle as commit -> no error.
REQ-045 aresetn asserted in WAIT -> outputs 0 immediately; after release the next commit has seq 0, bank 0.
REQ-046 Seq preloaded near wrap via force -> 0xFFFFFFFF followed by 0x00000000.
